// File: rtl/shift_out_sm.sv
// shift_out_sm: serialises 16-bit words from the nibble shift-in stage back out
// as NIB_W-bit nibbles, MSB nibble first, under a valid/ready handshake.
// A one-word holding register accepts the next word while the current one shifts;
// words arriving while it is full are dropped and flag a sticky overflow.
//
// Optional feature macro: CHECKSUM_EN
//   When defined, each word is followed by one extra nibble holding the XOR of
//   its data nibbles; count loads NIBBLES+1 on word load.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous reset, active-low
//   i_ena        word-valid strobe; i_din captured when i_ena=1 and o_ready=1
//   i_din        input word (WORD_W bits)
//   o_ready      holding register empty
//   o_dout       current nibble (top nibble of the shift register)
//   o_dvalid     o_dout is valid
//   i_dready     downstream accepts o_dout when o_dvalid=1
//   o_count      nibbles remaining in the current word, including o_dout; 0 when idle
//   o_word_done  one-cycle pulse after the last nibble of a word is accepted
//   o_overflow   sticky: a word arrived while the holding register was full
module shift_out_sm #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NIB_W  = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_ena,
  input  logic [WORD_W-1:0]                      i_din,
  output logic                                   o_ready,
  output logic [NIB_W-1:0]                       o_dout,
  output logic                                   o_dvalid,
  input  logic                                   i_dready,
  output logic [$clog2(WORD_W/NIB_W + 2)-1:0]    o_count,
  output logic                                   o_word_done,
  output logic                                   o_overflow
);

  localparam int unsigned NIBBLES = WORD_W / NIB_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES + 2);
`ifdef CHECKSUM_EN
  localparam int unsigned LOAD_CNT = NIBBLES + 1;
`else
  localparam int unsigned LOAD_CNT = NIBBLES;
`endif
  localparam logic [CNT_W-1:0] W_LOAD = CNT_W'(LOAD_CNT);

  typedef enum logic {StIdle, StShift} state_t;

  state_t             r_state;
  logic [WORD_W-1:0]  r_hold;
  logic               r_hold_valid;
  logic [WORD_W-1:0]  r_shreg;
  logic [CNT_W-1:0]   r_count;
  logic               r_word_done;
  logic               r_overflow;
`ifdef CHECKSUM_EN
  logic [NIB_W-1:0]   r_csum;
  logic [NIB_W-1:0]   w_csum_nxt;
`endif

  logic [NIB_W-1:0]   w_top;
  logic               w_last;

  assign w_top  = r_shreg[WORD_W-1 -: NIB_W];
  assign w_last = (r_count == CNT_W'(1));
`ifdef CHECKSUM_EN
  assign w_csum_nxt = r_csum ^ w_top;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shreg      <= '0;
      r_count      <= '0;
      r_word_done  <= 1'b0;
      r_overflow   <= 1'b0;
`ifdef CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_word_done <= 1'b0;

      // Capture needs an empty hold at cycle start, transfer needs a full one,
      // so the two hold_valid updates below can never collide.
      if (i_ena) begin
        if (!r_hold_valid) begin
          r_hold       <= i_din;
          r_hold_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (r_hold_valid) begin
            r_shreg      <= r_hold;
            r_hold_valid <= 1'b0;
            r_count      <= W_LOAD;
            r_state      <= StShift;
`ifdef CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        StShift: begin
          if (i_dready) begin
            if (!w_last) begin
              r_count <= r_count - CNT_W'(1);
`ifdef CHECKSUM_EN
              r_csum  <= w_csum_nxt;
              // Last data nibble leaving: the checksum takes its place on top.
              if (r_count == CNT_W'(2)) begin
                r_shreg <= {w_csum_nxt, {(WORD_W-NIB_W){1'b0}}};
              end else begin
                r_shreg <= r_shreg << NIB_W;
              end
`else
              r_shreg <= r_shreg << NIB_W;
`endif
            end else begin
              r_word_done <= 1'b1;
              if (r_hold_valid) begin
                // Reload straight from hold: back-to-back words, no bubble.
                r_shreg      <= r_hold;
                r_hold_valid <= 1'b0;
                r_count      <= W_LOAD;
`ifdef CHECKSUM_EN
                r_csum       <= '0;
`endif
              end else begin
                r_count <= '0;
                r_state <= StIdle;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_ready     = ~r_hold_valid;
  assign o_dout      = w_top;
  assign o_dvalid    = (r_state == StShift);
  assign o_count     = r_count;
  assign o_word_done = r_word_done;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_shift_out_sm.sv
// tb_shift_out_sm: scoreboard bench for shift_out_sm. A transaction-level model
// (hold slot occupancy + nibbles left in flight) decides which words are accepted
// and pushes their expected nibble stream; a monitor pops and compares.
// Honours CHECKSUM_EN the same way as the design.
module tb_shift_out_sm;

  localparam int NIB = 4;
`ifdef CHECKSUM_EN
  localparam int NT = 5;
`else
  localparam int NT = 4;
`endif

  logic        clk;
  logic        rst;
  logic        ena;
  logic [15:0] din;
  logic        ready;
  logic [3:0]  dout;
  logic        dvalid;
  logic        dready;
  logic [2:0]  count;
  logic        word_done;
  logic        overflow;

  shift_out_sm dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ena       (ena),
    .i_din       (din),
    .o_ready     (ready),
    .o_dout      (dout),
    .o_dvalid    (dvalid),
    .i_dready    (dready),
    .o_count     (count),
    .o_word_done (word_done),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] nib;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   m_busy;    // nibbles left in the word on the output
  bit   m_hold;    // hold slot occupied
  bit   m_ovf;
  int   n_checks;
  int   n_fail;
  int   n_pushed;
  int   n_popped;
  bit   mon_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output of one accepted word, straight from the word value.
  task automatic push_word(input logic [15:0] w);
    logic [3:0] cs;
    logic [3:0] n;
    exp_t e;
    cs = 4'h0;
    for (int i = 0; i < 4; i++) begin
      n     = 4'((w >> (12 - NIB * i)) & 16'hF);
      cs    = cs ^ n;
      e.nib = n;
      e.cnt = 3'(NT - i);
      exp_q.push_back(e);
      n_pushed++;
    end
`ifdef CHECKSUM_EN
    e.nib = cs;
    e.cnt = 3'd1;
    exp_q.push_back(e);
    n_pushed++;
`endif
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    bit old_hold;
    if (!rst) begin
      m_busy = 0;
      m_hold = 0;
      m_ovf  = 0;
      exp_q.delete();
      return;
    end
    old_hold = m_hold;
    if (m_busy == 0) begin
      if (old_hold) begin
        m_busy = NT;
        m_hold = 0;
      end
    end else if (dready) begin
      m_busy--;
      if (m_busy == 0 && old_hold) begin
        m_busy = NT;
        m_hold = 0;
      end
    end
    if (ena) begin
      if (!old_hold) begin
        m_hold = 1;
        push_word(din);
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    ena = 1'b1;
    din = w;
    tick();
    ena = 1'b0;
    din = $urandom();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"},      32'(dout),      32'h0);
    check({tag, "_dvalid"},    32'(dvalid),    32'h0);
    check({tag, "_ready"},     32'(ready),     32'h1);
    check({tag, "_count"},     32'(count),     32'h0);
    check({tag, "_word_done"}, 32'(word_done), 32'h0);
    check({tag, "_overflow"},  32'(overflow),  32'h0);
  endtask

  task automatic drain(input string tag);
    int i;
    ena    = 1'b0;
    dready = 1'b1;
    i = 0;
    while (i < 60 && !(m_busy == 0 && !m_hold && exp_q.size() == 0)) begin
      tick();
      i++;
    end
    idle(2);
    check({tag, "_drain_q"},    32'(exp_q.size()), 32'h0);
    check({tag, "_drain_busy"}, 32'(m_busy),       32'h0);
  endtask

  // Monitor: compares DUT outputs to the model away from the active edge.
  initial begin : monitor
    exp_t e;
    bit   exp_done;
    exp_done = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("word_done", 32'(word_done), 32'(exp_done));
        check("ready",     32'(ready),     32'(!m_hold));
        check("dvalid",    32'(dvalid),    32'(m_busy > 0));
        check("count",     32'(count),     32'(m_busy));
        check("overflow",  32'(overflow),  32'(m_ovf));
        exp_done = 0;
        if (dvalid) begin
          if (exp_q.size() == 0) begin
            check("dout_unexpected", 32'(dout), 32'hFFFF_FFFF);
          end else begin
            check("dout", 32'(dout), 32'(exp_q[0].nib));
            if (dready && rst) begin
              e = exp_q.pop_front();
              n_popped++;
              exp_done = (e.cnt == 3'd1);
            end
          end
        end
      end else begin
        exp_done = 0;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    n_checks = 0;
    n_fail   = 0;
    n_pushed = 0;
    n_popped = 0;
    mon_en   = 0;
    m_busy   = 0;
    m_hold   = 0;
    m_ovf    = 0;
    rst      = 1'b0;
    ena      = 1'b0;
    din      = 16'h0;
    dready   = 1'b1;

    idle(3);
    rst = 1'b1;
    check_reset_outputs("reset");
    mon_en = 1;

    // Single word
    send(16'h1234);
    idle(8);
    check("single_idle_dvalid", 32'(dvalid), 32'h0);

    // Back-to-back words, second one two cycles after the first
    send(16'h59A6);
    idle(1);
    send(16'hF00F);
    drain("b2b");

    // Stall while B is on the output
    send(16'hABCD);
    idle(2);
    dready = 1'b0;
    idle(3);
    check("stall_dout",  32'(dout),  32'hB);
    check("stall_count", 32'(count), 32'(NT - 1));
    dready = 1'b1;
    drain("stall");

    // Overflow: 1111 in flight, 2222 held, 3333 dropped
    send(16'h1111);
    idle(1);
    send(16'h2222);
    send(16'h3333);
    check("ovf_set", 32'(overflow), 32'h1);
    drain("ovf");
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Mid-word reset right after nibble A of 9ABC is accepted
    send(16'h9ABC);
    idle(2);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_reset_outputs("midreset");
    idle(3);
    check("midreset_quiet", 32'(dvalid), 32'h0);

    // Randomised traffic with stalls, overflows and occasional resets
    for (int i = 0; i < 3000; i++) begin
      ena    = ($urandom_range(0, 2) == 0);
      din    = 16'($urandom());
      dready = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 499) != 0);
      tick();
      rst = 1'b1;
    end
    drain("rand");
    check("words_consumed", 32'(n_popped > 100), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_out_sm.md
Name: shift_out_sm

Overview:
Downstream neighbour of the nibble shift-in stage. Takes each assembled 16-bit word, strobed by the shift-in stage's `ena` pulse, and serialises it back out as 4-bit nibbles, MSB nibble first, under a valid/ready handshake. A one-word holding register lets the next word arrive while the current word is still shifting. Words arriving while the holding register is full are dropped and flagged.

Parameters:
WORD_W, 16, input word width; must be a multiple of NIB_W.
NIB_W, 4, output nibble width.
NIBBLES, WORD_W/NIB_W (4), derived count of nibbles per word; local, not overridable.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low; sampled on rising clk edge.
ena  in  1  word-valid strobe from the shift-in stage; din is captured when ena=1 and ready=1.
din  in  16  word from the shift-in stage.
ready  out  1  holding register empty; a word can be accepted this cycle.
dout  out  4  current nibble, equal to shreg[15:12].
dvalid  out  1  dout is valid.
dready  in  1  downstream accepts dout when dvalid=1 and dready=1.
count  out  3  nibbles remaining in the current word, including the one on dout; 0 when idle.
word_done  out  1  one-cycle pulse after the last nibble of a word is accepted.
overflow  out  1  sticky flag: set when ena=1 and ready=0; the word is dropped.

Behaviour:
- Reset (rst=0 at a clk edge) values:
  - state=IDLE, hold_valid=0, shreg=0, count=0.
  - dout=0, dvalid=0, ready=1, word_done=0, overflow=0.
  - Reset applies mid-word: the partial word and any held word are discarded, with no word_done.
- ready = !hold_valid, registered; there is no same-cycle bypass.
- Capture: ena=1 and ready=1 -> hold<=din, hold_valid<=1.
- States:
  - IDLE: dvalid=0. If hold_valid=1: shreg<=hold, hold_valid<=0, count<=NIBBLES, go to SHIFT.
  - SHIFT: dvalid=1.
    - On dready=1 with count>1: shreg<=shreg<<NIB_W (zero fill), count<=count-1.
    - On dready=1 with count==1 (last nibble): word_done<=1.
      - If hold_valid=1, reload shreg from hold, clear hold_valid, set count<=NIBBLES, and stay in SHIFT. This gives back-to-back words with no bubble.
      - Otherwise go to IDLE with count<=0.
    - dready=0: all state holds; dout and dvalid are stable (stall).
- Latency: ena sampled at edge E0 -> first nibble on dout with dvalid=1 after edge E1, i.e. 2 cycles from ena. Minimum 4 cycles per word at dready=1.
- Simultaneous capture and hold-to-shreg transfer in the same cycle: the transfer uses the old hold. Capture is only possible if ready=1 at the start of the cycle, so these never conflict.
- overflow stays set until reset. A dropped word does not disturb the held word or the word in flight.
- word_done is high for exactly one cycle per completed word and is never asserted for dropped words.

Optional Feature:
CHECKSUM_EN
- Defined:
  - After the last data nibble, one extra nibble is emitted: the XOR of all NIBBLES data nibbles of that word, accumulated as they shift.
  - count loads NIBBLES+1 (5) on word load.
  - word_done pulses after the checksum nibble is accepted.
  - Minimum 5 cycles per word.
- Undefined: no checksum logic or accumulator register; behaviour is exactly as above.

Test Plan:
- Reset, then ena=1 with din=16'h1234 for one cycle, dready=1 -> dout sequence 1,2,3,4 on consecutive cycles with dvalid=1; count 4,3,2,1; word_done one cycle later; back to IDLE, dvalid=0. With CHECKSUM_EN, a fifth nibble 4 follows.
- Back-to-back: 16'h59A6, then 16'hF00F two cycles later, dready=1 -> nibbles 5,9,A,6,F,0,0,F with no dvalid gap; two word_done pulses.
- Stall: during 16'hABCD, hold dready=0 for 3 cycles while dout=B -> dout stays B and dvalid stays 1; then C,D resume; count is frozen during the stall.
- Overflow: word 16'h1111 in flight, 16'h2222 in hold, ena with 16'h3333 -> overflow=1 sticky; output is 1,1,1,1,2,2,2,2; 3333 never appears.
- Mid-word reset: rst=0 for one edge after the nibble A of 16'h9ABC -> all outputs return to reset values; no word_done; ready=1 on the next cycle.
